// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: display-scan inputs and decoded-frame outputs of seg_scan_decoder
interface seg_scan_decoder_if;
    logic [3:0]  anode_in;
    logic [6:0]  seg_in;
    logic [15:0] value;
    logic        frame_valid;
    logic        err_pattern;
    logic        err_anode;
    modport master (output anode_in, seg_in, input value, frame_valid, err_pattern, err_anode);
    modport slave (input anode_in, seg_in, output value, frame_valid, err_pattern, err_anode);
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers a 4-digit BCD value from a multiplexed 7-segment scan; sticky error flags built only with SEG_SCAN_ERR_EN
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 16
) (
    input logic         clk,
    input logic         master_reset,
    seg_scan_decoder_if.slave bus
);
    typedef enum logic [1:0] {WAIT_D0, HAVE_D0, HAVE_D1, HAVE_D2} state_t;
    localparam logic [7:0] LIMIT = 8'(STABLE_CYCLES);
    logic [10:0] sync1, sync2, prev;
    logic [7:0]  count;
    logic        strobe;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [1:0]  digit;
    logic        is_digit, is_blank;
    logic [3:0]  bcd;
    logic        bcd_ok;
    logic        bad_anode, bad_pattern;
    logic        store0, store1, store2, complete, abort;
    state_t      state, state_next;
    logic [3:0]  d0, d1, d2;
    logic [15:0] value_q;
    logic        fv_q;
    assign anode = sync2[10:7];
    assign seg = sync2[6:0];
    // two-flop synchronizer plus the previous-sample register used for change detection
    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            sync1 <= 11'h7FF;
            sync2 <= 11'h7FF;
            prev <= 11'h7FF;
        end else begin
            sync1 <= {bus.anode_in, bus.seg_in};
            sync2 <= sync1;
            prev <= sync2;
        end
    end
    // stability counter: restarts on any sample change, saturates at the limit
    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset)
            count <= '0;
        else
            count <= (sync2 != prev) ? '0 : (count == LIMIT) ? count : count + 8'd1;
    end
    assign strobe = (sync2 == prev) && (count == LIMIT - 8'd1);
    // anode decode: one-hot-low selects a digit, all-high is the blanking gap
    always_comb begin
        digit = 2'd0;
        is_digit = 1'b1;
        case (anode)
            4'b0111: digit = 2'd0;
            4'b1011: digit = 2'd1;
            4'b1101: digit = 2'd2;
            4'b1110: digit = 2'd3;
            default: is_digit = 1'b0;
        endcase
        is_blank = anode == 4'b1111;
    end
    // segment decode of active-low a..g patterns into BCD
    always_comb begin
        bcd = 4'd0;
        bcd_ok = 1'b1;
        case (seg)
            7'h01: bcd = 4'd0;
            7'h4F: bcd = 4'd1;
            7'h12: bcd = 4'd2;
            7'h06: bcd = 4'd3;
            7'h4C: bcd = 4'd4;
            7'h24: bcd = 4'd5;
            7'h20: bcd = 4'd6;
            7'h0F: bcd = 4'd7;
            7'h00: bcd = 4'd8;
            7'h04: bcd = 4'd9;
            default: bcd_ok = 1'b0;
        endcase
    end
    assign bad_anode = strobe && !is_digit && !is_blank;
    assign bad_pattern = strobe && is_digit && !bcd_ok;
    // frame state register
    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset)
            state <= WAIT_D0;
        else
            state <= state_next;
    end
    // frame sequencing: digit0 always restarts, anything out of order or erroneous aborts
    always_comb begin
        store0 = 1'b0;
        store1 = 1'b0;
        store2 = 1'b0;
        complete = 1'b0;
        abort = 1'b0;
        if (bad_anode || bad_pattern)
            abort = 1'b1;
        else if (strobe && is_digit) begin
            if (digit == 2'd0)
                store0 = 1'b1;
            else if (digit == 2'd1 && state == HAVE_D0)
                store1 = 1'b1;
            else if (digit == 2'd2 && state == HAVE_D1)
                store2 = 1'b1;
            else if (digit == 2'd3 && state == HAVE_D2)
                complete = 1'b1;
            else
                abort = 1'b1;
        end
        state_next = store0 ? HAVE_D0 : store1 ? HAVE_D1 : store2 ? HAVE_D2 :
                     (complete || abort) ? WAIT_D0 : state;
    end
    // partial digits, published value and frame pulse
    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            d0 <= '0;
            d1 <= '0;
            d2 <= '0;
            value_q <= '0;
            fv_q <= 1'b0;
        end else begin
            d0 <= store0 ? bcd : (abort || complete) ? 4'd0 : d0;
            d1 <= store1 ? bcd : (store0 || abort || complete) ? 4'd0 : d1;
            d2 <= store2 ? bcd : (store0 || store1 || abort || complete) ? 4'd0 : d2;
            value_q <= complete ? {bcd, d2, d1, d0} : value_q;
            fv_q <= complete;
        end
    end
    assign bus.value = value_q;
    assign bus.frame_valid = fv_q;
`ifdef SEG_SCAN_ERR_EN
    logic err_pattern_q, err_anode_q;
    // sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            err_pattern_q <= 1'b0;
            err_anode_q <= 1'b0;
        end else begin
            err_pattern_q <= err_pattern_q || bad_pattern;
            err_anode_q <= err_anode_q || bad_anode;
        end
    end
    assign bus.err_pattern = err_pattern_q;
    assign bus.err_anode = err_anode_q;
`else
    assign bus.err_pattern = 1'b0;
    assign bus.err_anode = 1'b0;
`endif
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scan sequences checked against hand-computed frames
module tb_seg_scan_decoder;
    logic clk = 1'b0;
    logic master_reset = 1'b1;
    int total = 0;
    int bad = 0;
    int fv_cnt = 0;
    int consec = 0;
    logic fv_last = 1'b0;
    int f;
`ifdef SEG_SCAN_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif
    logic [3:0] an_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [6:0] seg_tab [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

    seg_scan_decoder_if bus();
    seg_scan_decoder #(.STABLE_CYCLES(16)) dut (.clk(clk), .master_reset(master_reset), .bus(bus));

    always #5 clk = ~clk;

    // frame pulse bookkeeping, including back-to-back pulse detection
    always @(negedge clk) begin
        if (bus.frame_valid) begin
            fv_cnt++;
            if (fv_last) consec++;
        end
        fv_last = bus.frame_valid;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic slot(input int idx, input logic [6:0] seg, input int len, output int first);
        first = 0;
        bus.anode_in = an_tab[idx];
        bus.seg_in = seg;
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            if (bus.frame_valid && first == 0) first = i;
        end
    endtask

    initial begin
        bus.anode_in = 4'b1111;
        bus.seg_in = 7'h7F;
        repeat (3) @(negedge clk);
        check("reset_value", bus.value, 16'h0000);
        check("reset_fv", 16'(bus.frame_valid), 16'd0);
        check("reset_errp", 16'(bus.err_pattern), 16'd0);
        check("reset_erra", 16'(bus.err_anode), 16'd0);
        master_reset = 1'b0;
        repeat (25) @(negedge clk);
        check("blank_value", bus.value, 16'h0000);
        // three scans of 7,3,9,5
        for (int s = 0; s < 3; s++) begin
            slot(0, seg_tab[7], 64, f);
            check("scan_d0_nofv", 16'(f), 16'd0);
            slot(1, seg_tab[3], 64, f);
            slot(2, seg_tab[9], 64, f);
            check("scan_d2_nofv", 16'(f), 16'd0);
            slot(3, seg_tab[5], 64, f);
            check("scan_latency", 16'(f), 16'd19);
            check("scan_value", bus.value, 16'h5937);
        end
        check("scan_fv_count", 16'(fv_cnt), 16'd3);
        // glitch inside the digit1 slot must not be captured
        slot(0, seg_tab[1], 64, f);
        slot(1, seg_tab[2], 5, f);
        slot(1, 7'h7F, 10, f);
        slot(1, seg_tab[2], 49, f);
        slot(2, seg_tab[3], 64, f);
        slot(3, seg_tab[4], 64, f);
        check("glitch_latency", 16'(f), 16'd19);
        check("glitch_value", bus.value, 16'h4321);
        check("glitch_errp", 16'(bus.err_pattern), 16'd0);
        check("glitch_fv_count", 16'(fv_cnt), 16'd4);
        // non-BCD pattern on digit1 aborts the frame
        slot(0, seg_tab[1], 64, f);
        slot(1, 7'h7E, 64, f);
        slot(2, seg_tab[3], 64, f);
        slot(3, seg_tab[4], 64, f);
        check("pattern_nofv", 16'(f), 16'd0);
        check("pattern_value", bus.value, 16'h4321);
        check("pattern_errp", 16'(bus.err_pattern), 16'(EXP_ERR));
        check("pattern_erra", 16'(bus.err_anode), 16'd0);
        // out-of-order scan, then an in-order one
        slot(0, seg_tab[8], 64, f);
        slot(2, seg_tab[6], 64, f);
        slot(1, seg_tab[0], 64, f);
        slot(3, seg_tab[2], 64, f);
        check("order_nofv", 16'(f), 16'd0);
        check("order_value", bus.value, 16'h4321);
        slot(0, seg_tab[8], 64, f);
        slot(1, seg_tab[0], 64, f);
        slot(2, seg_tab[6], 64, f);
        slot(3, seg_tab[2], 64, f);
        check("inorder_latency", 16'(f), 16'd19);
        check("inorder_value", bus.value, 16'h2608);
        check("inorder_fv_count", 16'(fv_cnt), 16'd5);
        // illegal two-hot anode
        bus.anode_in = 4'b0011;
        bus.seg_in = seg_tab[5];
        repeat (64) @(negedge clk);
        check("anode_erra", 16'(bus.err_anode), 16'(EXP_ERR));
        check("anode_errp_sticky", 16'(bus.err_pattern), 16'(EXP_ERR));
        check("anode_value", bus.value, 16'h2608);
        // reset mid-frame after digit1
        slot(0, seg_tab[1], 64, f);
        slot(1, seg_tab[2], 64, f);
        master_reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_value", bus.value, 16'h0000);
        check("midrst_erra", 16'(bus.err_anode), 16'd0);
        check("midrst_errp", 16'(bus.err_pattern), 16'd0);
        master_reset = 1'b0;
        slot(2, seg_tab[3], 64, f);
        slot(3, seg_tab[4], 64, f);
        check("resume_nofv", 16'(f), 16'd0);
        check("resume_value", bus.value, 16'h0000);
        slot(0, seg_tab[5], 64, f);
        slot(1, seg_tab[6], 64, f);
        slot(2, seg_tab[7], 64, f);
        slot(3, seg_tab[8], 64, f);
        check("final_latency", 16'(f), 16'd19);
        check("final_value", bus.value, 16'h8765);
        check("final_fv_count", 16'(fv_cnt), 16'd6);
        check("fv_consecutive", 16'(consec), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
